// File: rtl/pulse_catch_array.sv
// Multi-channel feedback pulse catcher: per channel a 2-FF synchroniser, a
// minimum-width filter, leading/trailing catch and a wrapping caught-pulse counter.
module pulse_catch_array #(
  parameter int _CH_NUM    = 4,
  parameter int _RAM_WIDTH = 32,
  parameter int _CNT_WIDTH = 16
) (
  input  logic                             io_clk,
  input  logic                             io_rst,
  input  logic [_CH_NUM-1:0]               io_fb_in,
  input  logic [_CH_NUM-1:0]               io_enable,
  input  logic [_CH_NUM-1:0]               io_defaultLevel,
  input  logic [_CH_NUM-1:0]               io_mode,
  input  logic [_CH_NUM*_RAM_WIDTH-1:0]    io_filterCnt,
  input  logic [_CH_NUM-1:0]               io_cntClr,
  output logic [_CH_NUM-1:0]               io_fb_catch,
  output logic [_CH_NUM*_CNT_WIDTH-1:0]    io_pulseCnt,
  output logic [_CH_NUM-1:0]               io_cntOvf,
  output logic [2*_CH_NUM-1:0]             io_dbg_state
);

  typedef enum logic [1:0] {
    ST_WAIT_REL = 2'd0,
    ST_IDLE     = 2'd1,
    ST_MEASURE  = 2'd2,
    ST_HELD     = 2'd3
  } state_t;

  localparam logic [_RAM_WIDTH-1:0] ONE_W = {{(_RAM_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [_CNT_WIDTH-1:0] ONE_C = {{(_CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [_CH_NUM-1:0] r_sync1;
  logic [_CH_NUM-1:0] r_sync2;
  logic [_CH_NUM-1:0] r_act;
  logic [_CH_NUM-1:0] r_level_q;
  logic [_CH_NUM-1:0] r_mode_q;
  logic [_CH_NUM-1:0] w_cfg_chg;

  // r_act resets to the level so a pin stuck active out of reset reads as
  // active, matching the all-zero synchroniser.
  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_act     <= io_defaultLevel;
      r_level_q <= io_defaultLevel;
      r_mode_q  <= io_mode;
    end else begin
      r_sync1   <= io_fb_in;
      r_sync2   <= r_sync1;
      r_act     <= r_sync2 ^ io_defaultLevel;
      r_level_q <= io_defaultLevel;
      r_mode_q  <= io_mode;
    end
  end

  assign w_cfg_chg = (io_defaultLevel ^ r_level_q) | (io_mode ^ r_mode_q);

  genvar k;
  generate
    for (k = 0; k < _CH_NUM; k++) begin : g_ch
      state_t                r_state;
      state_t                w_state_nxt;
      logic [_RAM_WIDTH-1:0] r_width;
      logic [_RAM_WIDTH-1:0] w_width_nxt;
      logic [_RAM_WIDTH-1:0] w_width_inc;
      logic [_RAM_WIDTH-1:0] w_n;
      logic [_RAM_WIDTH-1:0] w_neff;
      logic                  w_catch;
      logic                  r_catch;
      logic [_CNT_WIDTH-1:0] r_cnt;
      logic                  r_ovf;

      assign w_n         = io_filterCnt[k*_RAM_WIDTH +: _RAM_WIDTH];
      assign w_neff      = (w_n == '0) ? ONE_W : w_n;
      assign w_width_inc = (&r_width) ? r_width : (r_width + ONE_W);

      always_comb begin
        w_state_nxt = r_state;
        w_width_nxt = r_width;
        w_catch     = 1'b0;
        if (!io_enable[k] || w_cfg_chg[k]) begin
          w_state_nxt = ST_WAIT_REL;
          w_width_nxt = '0;
        end else begin
          case (r_state)
            ST_WAIT_REL: begin
              w_width_nxt = '0;
              if (!r_act[k]) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
              w_width_nxt = '0;
              if (r_act[k]) begin
                w_width_nxt = ONE_W;
                if (w_neff != ONE_W) begin
                  w_state_nxt = ST_MEASURE;
                end else if (io_mode[k]) begin
                  w_state_nxt = ST_HELD;
                end else begin
                  w_catch     = 1'b1;
                  w_state_nxt = ST_WAIT_REL;
                  w_width_nxt = '0;
                end
              end
            end
            ST_MEASURE: begin
              if (!r_act[k]) begin
                w_state_nxt = ST_IDLE;
                w_width_nxt = '0;
              end else begin
                w_width_nxt = w_width_inc;
                if (w_width_inc >= w_neff) begin
                  if (io_mode[k]) begin
                    w_state_nxt = ST_HELD;
                  end else begin
                    w_catch     = 1'b1;
                    w_state_nxt = ST_WAIT_REL;
                    w_width_nxt = '0;
                  end
                end
              end
            end
            ST_HELD: begin
              if (!r_act[k]) begin
                w_catch     = 1'b1;
                w_state_nxt = ST_IDLE;
                w_width_nxt = '0;
              end else begin
                w_width_nxt = w_width_inc;
              end
            end
            default: begin
              w_state_nxt = ST_WAIT_REL;
              w_width_nxt = '0;
            end
          endcase
        end
      end

      // A clear coinciding with a catch keeps that catch in the fresh count.
      always_ff @(posedge io_clk) begin
        if (io_rst) begin
          r_state <= ST_WAIT_REL;
          r_width <= '0;
          r_catch <= 1'b0;
          r_cnt   <= '0;
          r_ovf   <= 1'b0;
        end else begin
          r_state <= w_state_nxt;
          r_width <= w_width_nxt;
          r_catch <= w_catch;
          if (io_cntClr[k]) begin
            r_cnt <= w_catch ? ONE_C : '0;
            r_ovf <= 1'b0;
          end else if (w_catch) begin
            r_cnt <= r_cnt + ONE_C;
            if (&r_cnt) r_ovf <= 1'b1;
          end
        end
      end

      assign io_fb_catch[k]                         = r_catch;
      assign io_pulseCnt[k*_CNT_WIDTH +: _CNT_WIDTH] = r_cnt;
      assign io_cntOvf[k]                           = r_ovf;
      assign io_dbg_state[2*k +: 2]                 = r_state;
    end
  endgenerate

endmodule

// File: tb/tb_pulse_catch_array.sv
// Bench for pulse_catch_array: directed scenarios plus random traffic, checked
// against a run-length reference model through an expected-catch queue.
module tb_pulse_catch_array;
  localparam int CH = 4;
  localparam int RW = 32;
  localparam int CW = 4;

  logic              io_clk = 1'b0;
  logic              io_rst;
  logic [CH-1:0]     io_fb_in;
  logic [CH-1:0]     io_enable;
  logic [CH-1:0]     io_defaultLevel;
  logic [CH-1:0]     io_mode;
  logic [CH*RW-1:0]  io_filterCnt;
  logic [CH-1:0]     io_cntClr;
  logic [CH-1:0]     io_fb_catch;
  logic [CH*CW-1:0]  io_pulseCnt;
  logic [CH-1:0]     io_cntOvf;
  logic [2*CH-1:0]   io_dbg_state;
  logic [RW-1:0]     n_cfg [CH];

  always #5 io_clk = ~io_clk;

  always_comb begin
    io_filterCnt = '0;
    for (int c = 0; c < CH; c++) io_filterCnt[c*RW +: RW] = n_cfg[c];
  end

  pulse_catch_array #(._CH_NUM(CH), ._RAM_WIDTH(RW), ._CNT_WIDTH(CW)) dut (
    .io_clk(io_clk), .io_rst(io_rst), .io_fb_in(io_fb_in), .io_enable(io_enable),
    .io_defaultLevel(io_defaultLevel), .io_mode(io_mode), .io_filterCnt(io_filterCnt),
    .io_cntClr(io_cntClr), .io_fb_catch(io_fb_catch), .io_pulseCnt(io_pulseCnt),
    .io_cntOvf(io_cntOvf), .io_dbg_state(io_dbg_state)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [39:0] exp_q[$];
  int catch_seen [CH];
  int last_catch [CH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: run-length of active samples plus armed/held flags.
  bit          m_s1 [CH];
  bit          m_s2 [CH];
  bit          m_act [CH];
  bit          m_armed [CH];
  bit          m_held [CH];
  bit          m_lvl_q [CH];
  bit          m_mode_q [CH];
  int          m_run [CH];
  logic [CW-1:0] m_cnt [CH];
  bit          m_ovf [CH];
  bit          a, caught;
  int          neff, nxt;

  initial begin
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = '0;
      catch_seen[c] = 0;
      last_catch[c] = 0;
    end
  end

  always @(posedge io_clk) begin
    cyc = cyc + 1;
    for (int c = 0; c < CH; c++) begin
      if (io_rst) begin
        m_s1[c] = 0; m_s2[c] = 0; m_act[c] = io_defaultLevel[c];
        m_armed[c] = 0; m_held[c] = 0; m_run[c] = 0;
        m_cnt[c] = '0; m_ovf[c] = 0;
      end else begin
        a = m_act[c];
        neff = (n_cfg[c] == 0) ? 1 : int'(n_cfg[c]);
        caught = 0;
        if (!io_enable[c] || io_defaultLevel[c] != m_lvl_q[c] || io_mode[c] != m_mode_q[c]) begin
          m_armed[c] = 0; m_held[c] = 0; m_run[c] = 0;
        end else if (!m_armed[c]) begin
          if (!a) m_armed[c] = 1;
        end else if (a) begin
          m_run[c]++;
          if (!m_held[c] && m_run[c] >= neff) begin
            if (!io_mode[c]) begin
              caught = 1; m_armed[c] = 0; m_run[c] = 0;
            end else begin
              m_held[c] = 1;
            end
          end
        end else begin
          if (m_held[c]) caught = 1;
          m_held[c] = 0; m_run[c] = 0;
        end
        if (io_cntClr[c]) begin
          m_cnt[c] = caught ? CW'(1) : CW'(0);
          m_ovf[c] = 0;
        end else if (caught) begin
          nxt = int'(m_cnt[c]) + 1;
          if (nxt == (1 << CW)) m_ovf[c] = 1;
          m_cnt[c] = CW'(nxt % (1 << CW));
        end
        if (caught) exp_q.push_back({cyc[31:0], 8'(c)});
        m_act[c] = m_s2[c] ^ io_defaultLevel[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = io_fb_in[c];
      end
      m_lvl_q[c] = io_defaultLevel[c];
      m_mode_q[c] = io_mode[c];
    end
  end

  logic [CH-1:0] exp_vec;
  logic [39:0]   ent;
  always @(negedge io_clk) begin
    exp_vec = '0;
    while (exp_q.size() > 0 && exp_q[0][39:8] == cyc[31:0]) begin
      ent = exp_q.pop_front();
      exp_vec[ent[1:0]] = 1'b1;
    end
    chk("catch_vec", 32'(io_fb_catch), 32'(exp_vec));
    for (int c = 0; c < CH; c++) begin
      if (io_fb_catch[c]) begin
        catch_seen[c]++;
        last_catch[c] = cyc;
      end
      chk("pulse_cnt", 32'(io_pulseCnt[c*CW +: CW]), 32'(m_cnt[c]));
      chk("cnt_ovf", 32'(io_cntOvf[c]), 32'(m_ovf[c]));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge io_clk);
  endtask

  task automatic pulse(input int c, input int width, output int se, output int fe);
    io_fb_in[c] = 1'b1;
    se = cyc + 1;
    tick(width);
    io_fb_in[c] = 1'b0;
    fe = cyc + 1;
  endtask

  int se, fe, base;

  initial begin
    io_rst = 1'b1; io_fb_in = '0; io_enable = '1; io_defaultLevel = '0;
    io_mode = '0; io_cntClr = '0;
    for (int c = 0; c < CH; c++) n_cfg[c] = 5;
    tick(3);
    chk("rst_catch", 32'(io_fb_catch), 32'h0);
    chk("rst_pulsecnt", 32'(io_pulseCnt), 32'h0);
    chk("rst_ovf", 32'(io_cntOvf), 32'h0);
    io_rst = 1'b0;
    tick(4);

    // leading catch, N=5
    base = catch_seen[0];
    pulse(0, 5, se, fe);
    tick(12);
    chk("t1_catch_count", catch_seen[0] - base, 1);
    chk("t1_latency", last_catch[0] - se, 7);
    chk("t1_pulsecnt", 32'(io_pulseCnt[3:0]), 1);
    pulse(0, 4, se, fe);
    tick(12);
    chk("t1_short_rejected", catch_seen[0] - base, 1);
    chk("t1_pulsecnt_kept", 32'(io_pulseCnt[3:0]), 1);

    // trailing catch, N=3
    io_mode[0] = 1'b1; n_cfg[0] = 3;
    tick(4);
    pulse(0, 10, se, fe);
    tick(10);
    chk("t2_catch_count", catch_seen[0] - base, 2);
    chk("t2_latency", last_catch[0] - fe, 3);
    pulse(0, 2, se, fe);
    tick(10);
    chk("t2_short_rejected", catch_seen[0] - base, 2);

    // inverted idle level and stuck-active pin out of reset
    io_mode[0] = 1'b0; io_fb_in[0] = 1'b1; io_defaultLevel[0] = 1'b1;
    tick(12);
    chk("t3_idle_high", catch_seen[0] - base, 2);
    io_fb_in[0] = 1'b0; tick(3); io_fb_in[0] = 1'b1;
    tick(12);
    chk("t3_low_pulse", catch_seen[0] - base, 3);
    io_fb_in[0] = 1'b0; io_rst = 1'b1; tick(2); io_rst = 1'b0;
    tick(20);
    chk("t3_stuck_no_catch", catch_seen[0] - base, 3);
    chk("t3_cnt_after_rst", 32'(io_pulseCnt[3:0]), 0);
    io_fb_in[0] = 1'b1; tick(1); io_fb_in[0] = 1'b0; tick(4); io_fb_in[0] = 1'b1;
    tick(10);
    chk("t3_after_release", catch_seen[0] - base, 4);
    io_fb_in[0] = 1'b0; io_defaultLevel[0] = 1'b0;
    tick(4);

    // N=1 back-to-back pulses
    n_cfg[1] = 1; tick(3);
    base = catch_seen[1];
    repeat (8) begin
      io_fb_in[1] = 1'b1; tick(1); io_fb_in[1] = 1'b0; tick(1);
    end
    tick(8);
    chk("t4_catch_count", catch_seen[1] - base, 8);
    chk("t4_pulsecnt", 32'(io_pulseCnt[7:4]), 8);

    // counter wrap and clear colliding with a catch
    n_cfg[2] = 1; tick(3);
    repeat (16) begin
      io_fb_in[2] = 1'b1; tick(1); io_fb_in[2] = 1'b0; tick(1);
    end
    tick(8);
    chk("t5_wrap_cnt", 32'(io_pulseCnt[11:8]), 0);
    chk("t5_wrap_ovf", 32'(io_cntOvf[2]), 1);
    base = catch_seen[2];
    io_fb_in[2] = 1'b1; tick(1); io_fb_in[2] = 1'b0; tick(2);
    io_cntClr[2] = 1'b1; tick(1); io_cntClr[2] = 1'b0;
    tick(4);
    chk("t5_clr_catch_seen", catch_seen[2] - base, 1);
    chk("t5_clr_cnt", 32'(io_pulseCnt[11:8]), 1);
    chk("t5_clr_ovf", 32'(io_cntOvf[2]), 0);

    // reset and enable drop mid-pulse
    n_cfg[3] = 6; base = catch_seen[3];
    io_fb_in[3] = 1'b1; tick(4);
    io_rst = 1'b1; io_fb_in[3] = 1'b0; tick(1); io_rst = 1'b0;
    tick(12);
    chk("t6_rst_abort", catch_seen[3] - base, 0);
    io_fb_in[3] = 1'b1; tick(4);
    io_enable[3] = 1'b0; tick(2); io_enable[3] = 1'b1;
    tick(6); io_fb_in[3] = 1'b0;
    tick(6);
    chk("t6_en_abort", catch_seen[3] - base, 0);

    // random traffic on all channels
    for (int c = 0; c < CH; c++) begin
      n_cfg[c] = $urandom_range(0, 6);
      io_mode[c] = 1'($urandom_range(0, 1));
      io_defaultLevel[c] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 3000; i++) begin
      io_rst = ($urandom_range(0, 499) == 0);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 2) == 0) io_fb_in[c] = ~io_fb_in[c];
        io_cntClr[c] = ($urandom_range(0, 79) == 0);
        if (!io_enable[c]) io_enable[c] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 149) == 0) io_enable[c] = 1'b0;
        if ($urandom_range(0, 199) == 0) io_defaultLevel[c] = ~io_defaultLevel[c];
        if ($urandom_range(0, 199) == 0) io_mode[c] = ~io_mode[c];
        if ($urandom_range(0, 99) == 0) n_cfg[c] = $urandom_range(0, 6);
      end
      tick(1);
    end
    io_rst = 1'b0; io_cntClr = '0; io_enable = '1;
    io_fb_in = io_defaultLevel;
    tick(20);
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
